// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, port indices, scheduler states.
// Also used by other allocators in the router.
package noc_pkg;

  localparam logic [2:0] FLIT_HEAD   = 3'b001;
  localparam logic [2:0] FLIT_BODY   = 3'b010;
  localparam logic [2:0] FLIT_TAIL   = 3'b100;
  localparam logic [2:0] FLIT_SINGLE = 3'b101;

  localparam int P_L = 0;
  localparam int P_N = 1;
  localparam int P_E = 2;
  localparam int P_W = 3;
  localparam int P_S = 4;

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_t;

  function automatic logic is_head(logic [2:0] f);
    return (f == FLIT_HEAD) || (f == FLIT_SINGLE);
  endfunction

  function automatic logic is_tail(logic [2:0] f);
    return (f == FLIT_TAIL) || (f == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/noc_output_scheduler_if.sv
// Output-port scheduler bundle: requests and flit types in,
// grant, mux select, transfer strobe and credit status out.
interface noc_output_scheduler_if #(
  parameter int NPORT   = 5,
  parameter int CREDITS = 4
);
  localparam int CW = $clog2(CREDITS + 1);

  logic [NPORT-1:0]   req;
  logic [3*NPORT-1:0] flit_id;
  logic               credit_in;
  logic [NPORT-1:0]   grant;
  logic [2:0]         sel;
  logic               fwd;
  logic [CW-1:0]      credits;
  logic               timeout;
  logic               credit_err;

  modport master (
    output req, flit_id, credit_in,
    input  grant, sel, fwd, credits, timeout, credit_err
  );

  modport slave (
    input  req, flit_id, credit_in,
    output grant, sel, fwd, credits, timeout, credit_err
  );
endinterface

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set cand bit scanning ptr, ptr+1, ...
// The lowest rotation offset wins, so the loop walks offsets downwards.
module rr_pick #(
  parameter int NPORT = 5
) (
  input  logic [NPORT-1:0] cand,
  input  logic [2:0]       ptr,
  output logic             valid,
  output logic [2:0]       index
);
  logic [2:0] j;

  always_comb begin
    valid = 1'b0;
    index = '0;
    j     = '0;
    for (int k = NPORT - 1; k >= 0; k--) begin
      j = 3'((int'(ptr) + k) % NPORT);
      if (cand[j]) begin
        valid = 1'b1;
        index = j;
      end
    end
  end
endmodule

// File: rtl/noc_output_scheduler.sv
// Wormhole round-robin scheduler for one router output port, with
// credit gating and a watchdog that force-releases a stalled owner.
module noc_output_scheduler
  import noc_pkg::*;
#(
  parameter int NPORT   = 5,
  parameter int CREDITS = 4,
  parameter int TIMEOUT = 64
) (
  input logic             clk,
  input logic             rst,
  noc_output_scheduler_if.slave bus
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  state_t           state, state_nx;
  logic [2:0]       owner, owner_nx;
  logic [2:0]       ptr, ptr_nx;
  logic [2:0]       sel_q, sel_nx;
  logic [NPORT-1:0] grant_q, grant_nx;
  logic [WW-1:0]    wd, wd_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             timeout_q, cerr_q;

  logic [NPORT-1:0] cand;
  logic             pick_v;
  logic [2:0]       pick_i;
  logic [2:0]       own_flit;
  logic             own_req;
  logic             fwd;
  logic             expire;
  logic             cerr_nx;
  logic [2:0]       ptr_after;

  always_comb begin
    cand     = '0;
    own_flit = FLIT_BODY;
    own_req  = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      cand[i] = bus.req[i] && is_head(bus.flit_id[3*i +: 3]);
      if (owner == 3'(i)) begin
        own_flit = bus.flit_id[3*i +: 3];
        own_req  = bus.req[i];
      end
    end
  end

  rr_pick #(.NPORT(NPORT)) u_pick (
    .cand  (cand),
    .ptr   (ptr),
    .valid (pick_v),
    .index (pick_i)
  );

  assign fwd = (state == S_LOCKED) && own_req && (cnt != '0);
  assign ptr_after = (owner == 3'(NPORT - 1)) ? 3'd0 : owner + 3'd1;

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    ptr_nx   = ptr;
    sel_nx   = sel_q;
    grant_nx = grant_q;
    wd_nx    = wd;
    expire   = 1'b0;
    unique case (state)
      S_IDLE: begin
        wd_nx = '0;
        if (pick_v) begin
          state_nx = S_LOCKED;
          owner_nx = pick_i;
          sel_nx   = pick_i;
          grant_nx = NPORT'(1) << pick_i;
        end
      end
      S_LOCKED: begin
        if (fwd) begin
          wd_nx = '0;
          if (is_tail(own_flit)) begin
            state_nx = S_IDLE;
            grant_nx = '0;
            sel_nx   = '0;
            ptr_nx   = ptr_after;
          end
        end else if (wd == WW'(TIMEOUT - 1)) begin
          expire   = 1'b1;
          wd_nx    = '0;
          state_nx = S_IDLE;
          grant_nx = '0;
          sel_nx   = '0;
          ptr_nx   = ptr_after;
        end else begin
          wd_nx = wd + 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Simultaneous fwd and credit_in cancel out.
  always_comb begin
    cnt_nx  = cnt;
    cerr_nx = bus.credit_in && (cnt == CW'(CREDITS));
    if (fwd && !bus.credit_in)
      cnt_nx = cnt - 1'b1;
    else if (!fwd && bus.credit_in && !cerr_nx)
      cnt_nx = cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      owner     <= '0;
      ptr       <= '0;
      sel_q     <= '0;
      grant_q   <= '0;
      wd        <= '0;
      cnt       <= CW'(CREDITS);
      timeout_q <= 1'b0;
      cerr_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      owner     <= owner_nx;
      ptr       <= ptr_nx;
      sel_q     <= sel_nx;
      grant_q   <= grant_nx;
      wd        <= wd_nx;
      cnt       <= cnt_nx;
      timeout_q <= expire;
      cerr_q    <= cerr_nx;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.sel        = sel_q;
  assign bus.fwd        = fwd;
  assign bus.credits    = cnt;
  assign bus.timeout    = timeout_q;
  assign bus.credit_err = cerr_q;
endmodule
